// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle with wrap.
module scan_dwell_cnt #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign wrap = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Steps a 4:1 mux select through all channels and assembles the captured bits into a frame.
// Optional continuous rescanning is enabled by defining MUX_SCAN_CONT_EN.
module mux4_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [NCH-1:0]   sample,
    output logic             sample_valid
);

    // start is a level request sampled only in IDLE; abort wins over start and
    // over any capture on the same edge, and is ignored in IDLE.

    scan_state_t      state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [NCH-1:0]   shadow, shadow_n;
    logic [NCH-1:0]   sample_n;
    logic             sample_valid_n;
    logic             done_n;
    logic             cnt_clr, cnt_en, cnt_wrap;

    scan_dwell_cnt #(.DWELL(DWELL)) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .wrap  (cnt_wrap)
    );

    assign busy = (state == SCAN);

    always_comb begin
        state_n        = state;
        sel_n          = sel;
        shadow_n       = shadow;
        sample_n       = sample;
        sample_valid_n = sample_valid;
        done_n         = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = SCAN;
                    sel_n   = '0;
                    cnt_clr = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_n  = IDLE;
                    sel_n    = '0;
                    shadow_n = '0;
                    cnt_clr  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_wrap) begin
                        shadow_n[sel] = mux_out;
                        sel_n         = sel + 1'b1;
                        if (sel == SEL_W'(NCH - 1)) begin
                            // Last channel goes straight into sample so the frame updates atomically.
                            sample_n       = {mux_out, shadow[NCH-2:0]};
                            sample_valid_n = 1'b1;
                            done_n         = 1'b1;
`ifdef MUX_SCAN_CONT_EN
                            state_n        = SCAN;
`else
                            state_n        = IDLE;
`endif
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel          <= '0;
            shadow       <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            sel          <= sel_n;
            shadow       <= shadow_n;
            sample       <= sample_n;
            sample_valid <= sample_valid_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: two instances (DWELL=1 and DWELL=3) each feeding a modelled 4:1 mux.
module tb_mux4_scan_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] abort_v = '0;
    logic [3:0] in1 = '0;
    logic [3:0] in3 = '0;

    logic [1:0] sel1, sel3;
    logic       busy1, busy3, done1, done3, sv1, sv3;
    logic [3:0] smp1, smp3;
    logic       mux1, mux3;

    assign mux1 = in1[sel1];
    assign mux3 = in3[sel3];

    always #5 clk = ~clk;

`ifdef MUX_SCAN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    mux4_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .mux_out(mux1),
        .sel(sel1), .busy(busy1), .done(done1), .sample(smp1), .sample_valid(sv1)
    );

    mux4_scan_ctrl #(.DWELL(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .mux_out(mux3),
        .sel(sel3), .busy(busy3), .done(done3), .sample(smp3), .sample_valid(sv3)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] exp_sample [2];
    logic       exp_valid  [2];
    logic [3:0] exp_q [$];

    function automatic logic [3:0] get_sel(input int w);
        return w == 1 ? {2'b00, sel3} : {2'b00, sel1};
    endfunction
    function automatic logic [3:0] get_busy(input int w);
        return w == 1 ? {3'b000, busy3} : {3'b000, busy1};
    endfunction
    function automatic logic [3:0] get_done(input int w);
        return w == 1 ? {3'b000, done3} : {3'b000, done1};
    endfunction
    function automatic logic [3:0] get_sample(input int w);
        return w == 1 ? smp3 : smp1;
    endfunction
    function automatic logic [3:0] get_valid(input int w);
        return w == 1 ? {3'b000, sv3} : {3'b000, sv1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input logic [3:0] v);
        if (w == 1) in3 = v;
        else        in1 = v;
    endtask

    task automatic chk(input string tag, input int w, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s[dwell%0d]: observed %h expected %h", tag, (w == 1) ? 3 : 1, obs, exp);
        end
    endtask

    task automatic check_idle(input int w, input string tag);
        chk({tag, "_busy"},  w, get_busy(w),   4'd0);
        chk({tag, "_done"},  w, get_done(w),   4'd0);
        chk({tag, "_sel"},   w, get_sel(w),    4'd0);
        chk({tag, "_smp"},   w, get_sample(w), exp_sample[w]);
        chk({tag, "_valid"}, w, get_valid(w),  {3'b000, exp_valid[w]});
    endtask

    // Runs nfr frames on instance w; abort_at >= 0 aborts the last frame after edge E0+abort_at.
    task automatic run_scan(input int w, input logic [3:0] first_din, input int nfr, input int abort_at);
        int         d;
        logic [3:0] din;
        d   = (w == 1) ? 3 : 1;
        din = first_din;
        set_in(w, din);
        exp_q.push_back(din);
        start_v[w] = 1'b1;
        step();
        start_v[w] = 1'b0;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 4 * d; k++) begin
                chk("scan_sel",  w, get_sel(w),  4'(k / d));
                chk("scan_busy", w, get_busy(w), 4'd1);
                chk("scan_done", w, get_done(w), {3'b000, (CONT && f > 0 && k == 0)});
                if (f == nfr - 1 && k == abort_at) begin
                    abort_v[w] = 1'b1;
                    step();
                    abort_v[w] = 1'b0;
                    void'(exp_q.pop_back());
                    check_idle(w, "abort");
                    return;
                end
                step();
            end
            chk("frame_done",  w, get_done(w),   4'd1);
            chk("frame_smp",   w, get_sample(w), exp_q.pop_front());
            chk("frame_valid", w, get_valid(w),  4'd1);
            chk("frame_sel",   w, get_sel(w),    4'd0);
            chk("frame_busy",  w, get_busy(w),   {3'b000, CONT});
            exp_sample[w] = get_sample(w) === din ? din : din;
            exp_valid[w]  = 1'b1;
            if (f < nfr - 1) begin
                din = 4'($urandom_range(0, 15));
                set_in(w, din);
                exp_q.push_back(din);
`ifndef MUX_SCAN_CONT_EN
                start_v[w] = 1'b1;
                step();
                start_v[w] = 1'b0;
`endif
            end else begin
`ifdef MUX_SCAN_CONT_EN
                abort_v[w] = 1'b1;
                step();
                abort_v[w] = 1'b0;
`else
                step();
`endif
                check_idle(w, "end");
            end
        end
    endtask

    initial begin
        int w, nfr, d, ab;
        exp_sample[0] = '0; exp_sample[1] = '0;
        exp_valid[0]  = 1'b0; exp_valid[1] = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        check_idle(0, "reset");
        check_idle(1, "reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        run_scan(0, 4'b0101, 1, -1);
        run_scan(1, 4'b0011, 1, -1);
        run_scan(0, 4'b1111, 1, 1);
        run_scan(1, 4'b1001, 2, -1);
        run_scan(0, 4'b0110, 3, -1);
        run_scan(1, 4'b1110, 1, 11);

        start_v = 2'b11;
        abort_v = 2'b11;
        step();
        check_idle(0, "start_abort");
        check_idle(1, "start_abort");
        step();
        start_v = 2'b00;
        abort_v = 2'b00;

        for (int i = 0; i < 10; i++) begin
            w   = $urandom_range(0, 1);
            d   = (w == 1) ? 3 : 1;
            nfr = $urandom_range(1, 3);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4 * d - 1) : -1;
            run_scan(w, 4'($urandom_range(0, 15)), nfr, ab);
        end

        set_in(1, 4'b1010);
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        exp_sample[0] = '0; exp_sample[1] = '0;
        exp_valid[0]  = 1'b0; exp_valid[1] = 1'b0;
        exp_q.delete();
        check_idle(0, "async_rst");
        check_idle(1, "async_rst");
        rst_n = 1'b1;
        step();

        run_scan(1, 4'b1010, 1, -1);
        run_scan(0, 4'b0001, 2, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
